// File: rtl/alu_sequencer.sv
// alu_sequencer: round-robin sharing of a registered 64-bit ALU between two requesters,
// with op-dependent settle time before the enable pulse and a valid/ready response channel.
module alu_sequencer #(
    parameter int WIDTH      = 64,
    parameter int SIMPLE_CYC = 1,
    parameter int MUL_CYC    = 4,
    parameter int DIV_CYC    = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0_valid,
    input  logic [4:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_ctrl,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_out
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
    state_t state, state_n;
    logic             rr, id_q, g0, g1, legal, busy;
    logic [4:0]       op_q, g_op;
    logic [WIDTH-1:0] a_q, b_q, g_a, g_b;
    logic [15:0]      cnt, lat;
    // Grants are gated by clr so no ready pulse escapes while reset is held
    assign g0 = clr && state == IDLE && req0_valid && (!req1_valid || !rr);
    assign g1 = clr && state == IDLE && req1_valid && (!req0_valid || rr);
    assign req0_ready = g0;
    assign req1_ready = g1;
    assign g_op = g1 ? req1_op : req0_op;
    assign g_a = g1 ? req1_a : req0_a;
    assign g_b = g1 ? req1_b : req0_b;
    assign legal = g_op < 5'd12 && !(g_op == 5'd3 && g_b == '0);
    assign lat = g_op == 5'd2 ? 16'(MUL_CYC) : g_op == 5'd3 ? 16'(DIV_CYC) : 16'(SIMPLE_CYC);
    assign busy = state == EXEC || state == CAPT;
    assign alu_a = busy ? a_q : '0;
    assign alu_b = busy ? b_q : '0;
    assign alu_ctrl = busy ? op_q : 5'd0;
    assign resp_valid = state == RESP;
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_n;
    end
    always_comb begin
        state_n = state;
        alu_en = 1'b0;
        case (state)
            IDLE: state_n = (g0 || g1) ? (legal ? EXEC : RESP) : IDLE;
            EXEC: begin
                alu_en = cnt == '0;
                state_n = alu_en ? CAPT : EXEC;
            end
            CAPT: state_n = RESP;
            RESP: state_n = resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rr <= 1'b0;
            id_q <= 1'b0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
            resp_id <= 1'b0;
            resp_data <= '0;
            resp_err <= 1'b0;
        end else if (g0 || g1) begin
            rr <= ~g1;
            id_q <= g1;
            op_q <= g_op;
            a_q <= g_a;
            b_q <= g_b;
            cnt <= lat - 16'd1;
            if (!legal) begin
                resp_id <= g1;
                resp_data <= '0;
                resp_err <= 1'b1;
            end
        end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - 16'd1;
        end else if (state == CAPT) begin
            resp_id <= id_q;
            resp_data <= alu_out;
            resp_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of arbitration, latency, error responses, stalls and reset.
module tb_alu_sequencer;
    localparam int W = 64;
    logic         clk = 1'b0, clr = 1'b0, resp_ready = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready, resp_valid, resp_id, resp_err, alu_en;
    logic [W-1:0] resp_data, alu_a, alu_b;
    logic [W-1:0] alu_out = '0;
    logic [4:0]   alu_ctrl;
    int           checks = 0, errors = 0;

    alu_sequencer dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err), .resp_ready(resp_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_en(alu_en), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // Reference ALU: registered result, updated only on enable
    always @(posedge clk)
        if (alu_en)
            case (alu_ctrl)
                5'd0: alu_out <= alu_a + alu_b;
                5'd1: alu_out <= alu_a - alu_b;
                5'd2: alu_out <= alu_a * alu_b;
                5'd3: alu_out <= alu_b == '0 ? '0 : alu_a / alu_b;
                default: alu_out <= alu_a ^ alu_b;
            endcase

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic wait_resp(input string tag);
        for (int c = 0; c < 20 && !resp_valid; c++) step();
        check({tag, "_resp_valid"}, W'(resp_valid), 1);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        step();
        check("rst_resp_valid", W'(resp_valid), 0);
        check("rst_alu_en", W'(alu_en), 0);
        check("rst_resp_data", resp_data, 0);
        step();
        clr = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic id, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat, input logic [W-1:0] exp, input logic err);
        int en_n, en_at, rv_at;
        logic [4:0] en_ctrl;
        en_n = 0; en_at = -1; rv_at = -1; en_ctrl = '0;
        step();
        drive(id, op, a, b);
        #1;
        check({tag, "_ready"}, W'(id ? req1_ready : req0_ready), 1);
        for (int c = 1; c <= 20 && rv_at < 0; c++) begin
            step();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            if (alu_en) begin en_n++; en_at = c; en_ctrl = alu_ctrl; end
            if (resp_valid) rv_at = c;
        end
        check({tag, "_en_count"}, W'(en_n), err ? 0 : 1);
        check({tag, "_en_at"}, W'(en_at), err ? '1 : W'(lat));
        check({tag, "_resp_at"}, W'(rv_at), err ? 1 : W'(lat + 2));
        if (!err) check({tag, "_ctrl"}, W'(en_ctrl), W'(op));
        check({tag, "_id"}, W'(resp_id), W'(id));
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_err"}, W'(resp_err), W'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g[$];
        int seen;
        do_reset();
        run_op("add", 1'b0, 5'd0, 64'd5, 64'd7, 1, 64'd12, 1'b0);
        run_op("mul", 1'b1, 5'd2, 64'd3, 64'd4, 4, 64'd12, 1'b0);
        run_op("div", 1'b0, 5'd3, 64'd100, 64'd7, 8, 64'd14, 1'b0);
        run_op("div0", 1'b0, 5'd3, 64'd9, 64'd0, 0, 64'd0, 1'b1);
        run_op("op15", 1'b1, 5'd15, 64'd1, 64'd2, 0, 64'd0, 1'b1);
        run_op("op11", 1'b1, 5'd11, 64'h0f, 64'hf0, 1, 64'hff, 1'b0);

        step();
        do_reset();
        drive(1'b0, 5'd0, 64'd1, 64'd2);
        drive(1'b1, 5'd0, 64'd10, 64'd20);
        for (int c = 0; c < 40 && g.size() < 4; c++) begin
            #1;
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
            if (resp_valid) check("rr_data", resp_data, resp_id ? 64'd30 : 64'd3);
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_grants", W'(g.size()), 4);
        for (int k = 0; k < g.size(); k++) check("rr_order", W'(g[k]), W'(k % 2));
        wait_resp("rr_last");
        check("rr_last_data", resp_data, 64'd30);

        step();
        resp_ready = 1'b0;
        drive(1'b0, 5'd1, 64'd50, 64'd8);
        #1;
        check("stall_ready", W'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        wait_resp("stall");
        drive(1'b1, 5'd0, 64'd4, 64'd4);
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_valid", W'(resp_valid), 1);
            check("stall_data", resp_data, 64'd42);
            check("stall_id", W'(resp_id), 0);
            check("stall_no_ready", W'({req0_ready, req1_ready}), 0);
        end
        resp_ready = 1'b1;
        #1;
        check("release_no_ready", W'(req1_ready), 0);
        step();
        check("release_next_ready", W'(req1_ready), 1);
        step();
        req1_valid = 1'b0;
        wait_resp("after_stall");
        check("after_stall_data", resp_data, 64'd8);
        check("after_stall_id", W'(resp_id), 1);

        step();
        drive(1'b0, 5'd3, 64'd100, 64'd7);
        #1;
        check("clr_div_ready", W'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        step();
        step();
        drive(1'b1, 5'd0, 64'd1, 64'd1);
        #2;
        clr = 1'b0;
        #1;
        check("clr_alu_a", alu_a, 0);
        check("clr_alu_b", alu_b, 0);
        check("clr_alu_ctrl", W'(alu_ctrl), 0);
        check("clr_alu_en", W'(alu_en), 0);
        check("clr_resp", W'({resp_valid, resp_id, resp_err}), 0);
        check("clr_resp_data", resp_data, 0);
        check("clr_ready", W'({req0_ready, req1_ready}), 0);
        step();
        clr = 1'b1;
        req1_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (resp_valid || alu_en) seen++;
        end
        check("clr_no_stale", W'(seen), 0);
        drive(1'b0, 5'd0, 64'd1, 64'd1);
        drive(1'b1, 5'd0, 64'd2, 64'd2);
        #1;
        check("clr_rr_ready0", W'(req0_ready), 1);
        check("clr_rr_ready1", W'(req1_ready), 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp("clr_post");
        check("clr_post_data", resp_data, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
